// File: rtl/pci_target_axil.sv
// PCI target to AXI4-Lite bridge: posted writes through a small FIFO, delayed reads
// held in a single slot with retry, BAR index folded into the AXI address.
module pci_target_axil #(
    parameter int ADDR_VALID_BITS = 24,
    parameter int WFIFO_DEPTH     = 4,
    parameter int RD_WAIT         = 16,
    parameter int AXI_AW          = ADDR_VALID_BITS + 3
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [31:0]                    addr_i,
    input  logic                           addr_vld_i,
    input  logic [7:0]                     base_hit_i,
    input  logic                           s_wrdn_i,
    input  logic [31:0]                    adio_out_i,
    output logic [31:0]                    adio_in_o,
    input  logic [3:0]                     s_cbe_i,
    input  logic                           s_data_i,
    input  logic                           s_data_vld_i,
    input  logic                           s_src_en_i,
    output logic                           s_ready_o,
    output logic                           s_term_o,
    output logic                           s_abort_o,
    output logic [AXI_AW-1:0]              tgt_m_awaddr_o,
    output logic                           tgt_m_awvalid_o,
    input  logic                           tgt_m_awready_i,
    output logic [31:0]                    tgt_m_wdata_o,
    output logic [3:0]                     tgt_m_wstrb_o,
    output logic                           tgt_m_wvalid_o,
    input  logic                           tgt_m_wready_i,
    input  logic [1:0]                     tgt_m_bresp_i,
    input  logic                           tgt_m_bvalid_i,
    output logic                           tgt_m_bready_o,
    output logic [AXI_AW-1:0]              tgt_m_araddr_o,
    output logic                           tgt_m_arvalid_o,
    input  logic                           tgt_m_arready_i,
    input  logic [31:0]                    tgt_m_rdata_i,
    input  logic [1:0]                     tgt_m_rresp_i,
    input  logic                           tgt_m_rvalid_i,
    output logic                           tgt_m_rready_o,
    output logic                           wr_err_o,
    output logic [$clog2(WFIFO_DEPTH):0]   wfifo_level_o
);
    localparam int PW = $clog2(WFIFO_DEPTH);
    localparam int LW = PW + 1;
    localparam int CW = (RD_WAIT > 1) ? $clog2(RD_WAIT) : 1;

    typedef enum logic [2:0] {S_IDLE, S_WR, S_RD_WAIT, S_RD_DONE, S_RETRY, S_ABORT} state_t;

    state_t              state_q, state_d;
    logic [AXI_AW-1:0]   cur_addr_q, cur_addr_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [31:0]         adio_in_q, adio_in_d;
    logic [2:0]          hit_idx;
    logic                push, pop, claim, free;

    logic [AXI_AW-1:0]   fifo_addr_q [WFIFO_DEPTH];
    logic [31:0]         fifo_data_q [WFIFO_DEPTH];
    logic [3:0]          fifo_strb_q [WFIFO_DEPTH];
    logic [PW-1:0]       wptr_q, rptr_q;
    logic [LW-1:0]       level_q;
    logic                fifo_full, fifo_empty;

    logic                wr_busy_q, awvalid_q, wvalid_q, wr_err_q;
    logic                slot_busy_q, slot_full_q, arvalid_q, rready_q;
    logic [AXI_AW-1:0]   slot_addr_q;
    logic [31:0]         slot_data_q;
    logic [1:0]          slot_resp_q;

    logic unused_ok;
    assign unused_ok = ^{s_src_en_i, addr_vld_i, addr_i[31:ADDR_VALID_BITS]};

    assign fifo_full  = (level_q == LW'(WFIFO_DEPTH));
    assign fifo_empty = (level_q == '0);

    always_comb begin
        hit_idx = '0;
        for (int i = 7; i >= 0; i--) begin
            if (base_hit_i[i]) hit_idx = 3'(i);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            cur_addr_q <= '0;
            cnt_q      <= '0;
            adio_in_q  <= '0;
        end else begin
            state_q    <= state_d;
            cur_addr_q <= cur_addr_d;
            cnt_q      <= cnt_d;
            adio_in_q  <= adio_in_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cur_addr_d = cur_addr_q;
        cnt_d      = cnt_q;
        adio_in_d  = adio_in_q;
        s_ready_o  = 1'b0;
        s_term_o   = 1'b0;
        s_abort_o  = 1'b0;
        push       = 1'b0;
        claim      = 1'b0;
        free       = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (base_hit_i != '0) begin
                    cur_addr_d = {hit_idx, addr_i[ADDR_VALID_BITS-1:0]};
                    cnt_d      = CW'(RD_WAIT - 1);
                    state_d    = s_wrdn_i ? S_WR : S_RD_WAIT;
                end
            end
            S_WR: begin
                if (!s_data_i) begin
                    state_d = S_IDLE;
                end else if (fifo_full) begin
                    s_term_o = 1'b1;
                    state_d  = S_IDLE;
                end else if (s_data_vld_i) begin
                    push      = 1'b1;
                    s_ready_o = 1'b1;
                    s_term_o  = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            S_RD_WAIT: begin
                if (!s_data_i) begin
                    state_d = S_IDLE;
                end else if (slot_busy_q && (slot_addr_q != cur_addr_q)) begin
                    state_d = S_RETRY;
                end else if (slot_full_q) begin
                    free = 1'b1;
                    if (slot_resp_q == 2'b00) begin
                        adio_in_d = slot_data_q;
                        state_d   = S_RD_DONE;
                    end else begin
                        state_d = S_ABORT;
                    end
                end else begin
                    // Posted writes must reach AXI before the read is issued.
                    claim = !slot_busy_q && fifo_empty;
                    if (cnt_q == '0) state_d = S_RETRY;
                    else             cnt_d   = cnt_q - 1'b1;
                end
            end
            S_RD_DONE: begin
                s_ready_o = 1'b1;
                s_term_o  = 1'b1;
                state_d   = S_IDLE;
            end
            S_RETRY: begin
                s_term_o = 1'b1;
                state_d  = S_IDLE;
            end
            S_ABORT: begin
                s_abort_o = 1'b1;
                s_term_o  = 1'b1;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_addr_q[wptr_q] <= cur_addr_q;
            fifo_data_q[wptr_q] <= adio_out_i;
            fifo_strb_q[wptr_q] <= ~s_cbe_i;
        end
    end

    assign tgt_m_bready_o = wr_busy_q && !awvalid_q && !wvalid_q;
    assign pop            = tgt_m_bready_o && tgt_m_bvalid_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            level_q   <= '0;
            wr_busy_q <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            wr_err_q  <= 1'b0;
        end else begin
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop)  rptr_q <= rptr_q + 1'b1;
            unique case ({push, pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
            if (!wr_busy_q && !fifo_empty) begin
                wr_busy_q <= 1'b1;
                awvalid_q <= 1'b1;
                wvalid_q  <= 1'b1;
            end else begin
                if (awvalid_q && tgt_m_awready_i) awvalid_q <= 1'b0;
                if (wvalid_q && tgt_m_wready_i)   wvalid_q  <= 1'b0;
                if (pop) begin
                    wr_busy_q <= 1'b0;
                    if (tgt_m_bresp_i != 2'b00) wr_err_q <= 1'b1;
                end
            end
        end
    end

    // Slot stays busy from AR issue until the matching PCI read collects it.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            slot_busy_q <= 1'b0;
            slot_full_q <= 1'b0;
            slot_addr_q <= '0;
            slot_data_q <= '0;
            slot_resp_q <= '0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
        end else begin
            if (claim) begin
                slot_busy_q <= 1'b1;
                slot_addr_q <= cur_addr_q;
                arvalid_q   <= 1'b1;
            end
            if (arvalid_q && tgt_m_arready_i) begin
                arvalid_q <= 1'b0;
                rready_q  <= 1'b1;
            end
            if (rready_q && tgt_m_rvalid_i) begin
                rready_q    <= 1'b0;
                slot_full_q <= 1'b1;
                slot_data_q <= tgt_m_rdata_i;
                slot_resp_q <= tgt_m_rresp_i;
            end
            if (free) begin
                slot_busy_q <= 1'b0;
                slot_full_q <= 1'b0;
            end
        end
    end

    assign adio_in_o       = adio_in_q;
    assign tgt_m_awaddr_o  = fifo_addr_q[rptr_q];
    assign tgt_m_wdata_o   = fifo_data_q[rptr_q];
    assign tgt_m_wstrb_o   = fifo_strb_q[rptr_q];
    assign tgt_m_awvalid_o = awvalid_q;
    assign tgt_m_wvalid_o  = wvalid_q;
    assign tgt_m_araddr_o  = slot_addr_q;
    assign tgt_m_arvalid_o = arvalid_q;
    assign tgt_m_rready_o  = rready_q;
    assign wr_err_o        = wr_err_q;
    assign wfifo_level_o   = level_q;

endmodule

// File: tb/tb_pci_target_axil.sv
// Bench for pci_target_axil: behavioural AXI4-Lite slave plus an ordered
// write queue and an address-to-data read function as the reference.
module tb_pci_target_axil;
    localparam int DEPTH = 4;
    localparam int RDW   = 16;

    typedef struct packed {
        logic [26:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] addr = '0;
    logic        addr_vld = 1'b0;
    logic [7:0]  base_hit = '0;
    logic        s_wrdn = 1'b0;
    logic [31:0] adio_out = '0;
    logic [31:0] adio_in;
    logic [3:0]  s_cbe = 4'hF;
    logic        s_data = 1'b0, s_data_vld = 1'b0, s_src_en = 1'b0;
    logic        s_ready, s_term, s_abort;
    logic [26:0] awaddr, araddr;
    logic        awvalid, wvalid, bready, arvalid, rready;
    logic        awready = 1'b0, wready = 1'b0, bvalid = 1'b0, arready = 1'b0, rvalid = 1'b0;
    logic [31:0] wdata, rdata = '0;
    logic [3:0]  wstrb;
    logic [1:0]  bresp = '0, rresp = '0;
    logic        wr_err;
    logic [2:0]  level;

    int errors = 0;
    int checks = 0;

    bit          aw_hold = 1'b0;
    bit          rand_mode = 1'b0;
    int          r_delay = 3;
    logic [1:0]  rresp_val = 2'b00;
    logic [1:0]  bresp_val = 2'b00;
    int          ar_count = 0;
    logic [26:0] last_araddr = '0;
    wr_t         axi_wr_q[$];
    wr_t         exp_q[$];

    pci_target_axil dut (
        .clk_i(clk), .rst_i(rst), .addr_i(addr), .addr_vld_i(addr_vld),
        .base_hit_i(base_hit), .s_wrdn_i(s_wrdn), .adio_out_i(adio_out),
        .adio_in_o(adio_in), .s_cbe_i(s_cbe), .s_data_i(s_data),
        .s_data_vld_i(s_data_vld), .s_src_en_i(s_src_en), .s_ready_o(s_ready),
        .s_term_o(s_term), .s_abort_o(s_abort),
        .tgt_m_awaddr_o(awaddr), .tgt_m_awvalid_o(awvalid), .tgt_m_awready_i(awready),
        .tgt_m_wdata_o(wdata), .tgt_m_wstrb_o(wstrb), .tgt_m_wvalid_o(wvalid),
        .tgt_m_wready_i(wready), .tgt_m_bresp_i(bresp), .tgt_m_bvalid_i(bvalid),
        .tgt_m_bready_o(bready), .tgt_m_araddr_o(araddr), .tgt_m_arvalid_o(arvalid),
        .tgt_m_arready_i(arready), .tgt_m_rdata_i(rdata), .tgt_m_rresp_i(rresp),
        .tgt_m_rvalid_i(rvalid), .tgt_m_rready_o(rready),
        .wr_err_o(wr_err), .wfifo_level_o(level)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_fn(input logic [26:0] a);
        return ({5'b0, a} * 32'd2654435761) ^ 32'hA5A5_1234;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // AXI4-Lite slave: handshakes are judged on values seen one posedge earlier.
    initial begin : axi_slave
        bit          aw_got, w_got, b_rdy_prev, r_rdy_prev;
        wr_t         cur;
        int          r_cnt;
        logic [26:0] ar_cap, r_addr;
        aw_got = 0; w_got = 0; b_rdy_prev = 0; r_rdy_prev = 0; r_cnt = -1;
        cur = '0; ar_cap = '0; r_addr = '0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                aw_got = 0; w_got = 0; b_rdy_prev = 0; r_rdy_prev = 0; r_cnt = -1;
                awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
            end else begin
                if (awready) aw_got = 1;
                if (wready)  w_got  = 1;
                if (bvalid && b_rdy_prev) bvalid = 0;
                awready = !aw_got && awvalid && !aw_hold && (!rand_mode || $urandom_range(0, 2) == 0);
                if (awready) cur.addr = awaddr;
                wready = !w_got && wvalid && (!rand_mode || $urandom_range(0, 2) == 0);
                if (wready) begin
                    cur.data = wdata;
                    cur.strb = wstrb;
                end
                if (aw_got && w_got && !bvalid) begin
                    axi_wr_q.push_back(cur);
                    bvalid = 1;
                    bresp  = bresp_val;
                    aw_got = 0;
                    w_got  = 0;
                end
                b_rdy_prev = bready;
                if (arready) begin
                    ar_count++;
                    last_araddr = ar_cap;
                    r_addr = ar_cap;
                    r_cnt = r_delay;
                end
                if (rvalid && r_rdy_prev) rvalid = 0;
                arready = arvalid;
                if (arready) ar_cap = araddr;
                if (r_cnt == 0) begin
                    rvalid = 1;
                    rdata  = mem_fn(r_addr);
                    rresp  = rresp_val;
                    r_cnt  = -1;
                end else if (r_cnt > 0) begin
                    r_cnt--;
                end
                r_rdy_prev = rready;
            end
        end
    end

    task automatic pci_write(input logic [7:0] bh, input logic [23:0] a, input logic [31:0] d,
                             input logic [3:0] cbe, output logic rdy, output logic term,
                             output logic [2:0] tail);
        addr = {8'($urandom), a}; base_hit = bh; s_wrdn = 1; addr_vld = 1;
        step();
        base_hit = '0; addr_vld = 0; s_data = 1; s_data_vld = 1; s_src_en = 1;
        adio_out = d; s_cbe = cbe;
        #1;
        rdy = s_ready; term = s_term;
        step();
        s_data = 0; s_data_vld = 0; s_src_en = 0; s_cbe = 4'hF;
        #1;
        tail = {s_ready, s_term, s_abort};
    endtask

    // res: 0 data, 1 retry, 2 abort, 3 no termination seen
    task automatic pci_read(input logic [7:0] bh, input logic [23:0] a, output int res,
                            output logic [31:0] data, output int cycles, output logic [2:0] tail);
        addr = {8'($urandom), a}; base_hit = bh; s_wrdn = 0; addr_vld = 1;
        step();
        base_hit = '0; addr_vld = 0; s_data = 1; s_src_en = 1;
        res = 3; data = '0; cycles = -1;
        for (int k = 0; k < 100; k++) begin
            #1;
            if (s_abort) begin res = 2; cycles = k; break; end
            if (s_ready && s_term) begin res = 0; data = adio_in; cycles = k; break; end
            if (s_term) begin res = 1; cycles = k; break; end
            step();
        end
        step();
        s_data = 0; s_src_en = 0;
        #1;
        tail = {s_ready, s_term, s_abort};
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (level != 0 && n < 1000) begin
            step();
            n++;
        end
        checks++;
        if (level != 0) begin
            errors++;
            $display("FAIL %s drain: wfifo_level=%0d after %0d cycles, required 0", name, level, n);
        end
    endtask

    task automatic compare_writes(input string name, input int base);
        checks++;
        if (axi_wr_q.size() - base != exp_q.size()) begin
            errors++;
            $display("FAIL %s count: axi writes=%0d required %0d", name, axi_wr_q.size() - base, exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && base + i < axi_wr_q.size(); i++) begin
            checks++;
            if (axi_wr_q[base + i] !== exp_q[i]) begin
                errors++;
                $display("FAIL %s item%0d: got addr=%h data=%h strb=%h required addr=%h data=%h strb=%h",
                         name, i, axi_wr_q[base + i].addr, axi_wr_q[base + i].data, axi_wr_q[base + i].strb,
                         exp_q[i].addr, exp_q[i].data, exp_q[i].strb);
            end
        end
    endtask

    task automatic test_reset();
        logic [45:0] obs;
        rst = 1;
        step();
        step();
        obs = {s_ready, s_term, s_abort, awvalid, wvalid, bready, arvalid, rready, wr_err, level, adio_in};
        checks++;
        if (obs !== '0) begin
            errors++;
            $display("FAIL reset_state: outputs=%h required 0", obs);
        end
        rst = 0;
        step();
        checks++;
        if (level !== 3'd0 || awvalid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: level=%0d awvalid=%b required 0/0", level, awvalid);
        end
    endtask

    task automatic test_single_write();
        logic rdy, term;
        logic [2:0] tail;
        int base;
        base = axi_wr_q.size();
        exp_q.delete();
        pci_write(8'h01, 24'h000010, 32'hDEADBEEF, 4'b0000, rdy, term, tail);
        checks++;
        if ({rdy, term} !== 2'b11) begin
            errors++;
            $display("FAIL wr_ack: ready/term=%b%b required 11", rdy, term);
        end
        checks++;
        if (tail !== 3'b000) begin
            errors++;
            $display("FAIL wr_ack_width: strobes next cycle=%b required 000", tail);
        end
        exp_q.push_back('{addr: 27'h0000010, data: 32'hDEADBEEF, strb: 4'hF});
        wait_drain("single_write");
        compare_writes("single_write", base);
    endtask

    task automatic test_fifo_full();
        logic rdy, term;
        logic [2:0] tail;
        logic [31:0] d;
        logic [3:0] cbe;
        int base;
        base = axi_wr_q.size();
        exp_q.delete();
        aw_hold = 1;
        for (int i = 0; i < DEPTH + 1; i++) begin
            d = $urandom;
            cbe = 4'($urandom);
            pci_write(8'h02, 24'(i * 4 + 24'h000400), d, cbe, rdy, term, tail);
            checks++;
            if (i < DEPTH) begin
                exp_q.push_back('{addr: {3'd1, 24'(i * 4 + 24'h000400)}, data: d, strb: ~cbe});
                if ({rdy, term} !== 2'b11) begin
                    errors++;
                    $display("FAIL full_accept%0d: ready/term=%b%b required 11", i, rdy, term);
                end
            end else if ({rdy, term} !== 2'b01) begin
                errors++;
                $display("FAIL full_retry: ready/term=%b%b required 01", rdy, term);
            end
        end
        checks++;
        if (level !== 3'(DEPTH)) begin
            errors++;
            $display("FAIL full_level: wfifo_level=%0d required %0d", level, DEPTH);
        end
        aw_hold = 0;
        wait_drain("fifo_full");
        compare_writes("fifo_full", base);
    endtask

    task automatic test_read_basic();
        int res, cyc, ar0;
        logic [31:0] d;
        logic [2:0] tail;
        r_delay = 3;
        ar0 = ar_count;
        pci_read(8'h04, 24'h000100, res, d, cyc, tail);
        checks++;
        if (res != 0 || cyc >= RDW) begin
            errors++;
            $display("FAIL rd_basic_term: result=%0d after %0d cycles, required data before %0d", res, cyc, RDW);
        end
        checks++;
        if (d !== mem_fn(27'h2000100)) begin
            errors++;
            $display("FAIL rd_basic_data: adio_in=%h required %h", d, mem_fn(27'h2000100));
        end
        checks++;
        if (last_araddr !== 27'h2000100 || ar_count - ar0 != 1) begin
            errors++;
            $display("FAIL rd_basic_ar: araddr=%h count=%0d required 2000100 count 1", last_araddr, ar_count - ar0);
        end
        checks++;
        if (tail !== 3'b000) begin
            errors++;
            $display("FAIL rd_basic_width: strobes next cycle=%b required 000", tail);
        end
    endtask

    task automatic test_read_retry();
        int res, cyc, ar0, tries;
        logic [31:0] d;
        logic [2:0] tail;
        r_delay = 40;
        ar0 = ar_count;
        pci_read(8'h08, 24'h0ABCDE, res, d, cyc, tail);
        checks++;
        if (res != 1 || cyc != RDW) begin
            errors++;
            $display("FAIL rd_timeout: result=%0d at cycle %0d, required retry at %0d", res, cyc, RDW);
        end
        pci_read(8'h08, 24'h000004, res, d, cyc, tail);
        checks++;
        if (res != 1 || cyc != 1) begin
            errors++;
            $display("FAIL rd_other_addr: result=%0d at cycle %0d, required retry at 1", res, cyc);
        end
        tries = 0;
        res = 1;
        while (res == 1 && tries < 6) begin
            pci_read(8'h08, 24'h0ABCDE, res, d, cyc, tail);
            tries++;
        end
        checks++;
        if (res != 0 || d !== mem_fn(27'h30ABCDE)) begin
            errors++;
            $display("FAIL rd_reissue: result=%0d data=%h required 0 / %h", res, d, mem_fn(27'h30ABCDE));
        end
        checks++;
        if (ar_count - ar0 != 1) begin
            errors++;
            $display("FAIL rd_single_ar: AR count=%0d required 1", ar_count - ar0);
        end
        r_delay = 3;
    endtask

    task automatic test_read_err();
        int res, cyc, ar0;
        logic [31:0] d;
        logic [2:0] tail;
        r_delay = 2;
        rresp_val = 2'b10;
        pci_read(8'h20, 24'h000200, res, d, cyc, tail);
        checks++;
        if (res != 2 || tail !== 3'b000) begin
            errors++;
            $display("FAIL rd_abort: result=%0d strobes after=%b required 2 / 000", res, tail);
        end
        rresp_val = 2'b00;
        ar0 = ar_count;
        pci_read(8'h20, 24'h000200, res, d, cyc, tail);
        checks++;
        if (res != 0 || d !== mem_fn(27'h5000200) || ar_count - ar0 != 1) begin
            errors++;
            $display("FAIL rd_after_abort: result=%0d data=%h ar=%0d required 0 / %h / 1",
                     res, d, ar_count - ar0, mem_fn(27'h5000200));
        end
    endtask

    task automatic test_bresp_err();
        logic rdy, term;
        logic [2:0] tail;
        checks++;
        if (wr_err !== 1'b0) begin
            errors++;
            $display("FAIL wr_err_clean: wr_err=%b required 0", wr_err);
        end
        bresp_val = 2'b11;
        pci_write(8'h01, 24'h000020, 32'h1234_5678, 4'h0, rdy, term, tail);
        wait_drain("bresp_err");
        bresp_val = 2'b00;
        checks++;
        if (wr_err !== 1'b1) begin
            errors++;
            $display("FAIL wr_err_set: wr_err=%b required 1", wr_err);
        end
        pci_write(8'h01, 24'h000024, 32'h0, 4'h0, rdy, term, tail);
        wait_drain("bresp_ok");
        checks++;
        if (wr_err !== 1'b1) begin
            errors++;
            $display("FAIL wr_err_sticky: wr_err=%b required 1", wr_err);
        end
    endtask

    task automatic test_random();
        logic rdy, term;
        logic [2:0] tail;
        logic [7:0] bh, m;
        logic [23:0] a;
        logic [31:0] d;
        logic [3:0] cbe;
        int bar, res, cyc, tries, base;
        base = axi_wr_q.size();
        exp_q.delete();
        rand_mode = 1;
        for (int n = 0; n < 30; n++) begin
            bar = $urandom_range(0, 7);
            m = 8'hFF;
            m = m << (bar + 1);
            bh = (8'd1 << bar) | (m & 8'($urandom));
            a = 24'($urandom);
            if ($urandom_range(0, 9) < 7) begin
                d = $urandom;
                cbe = 4'($urandom);
                tries = 0;
                rdy = 0;
                while (!rdy && tries < 30) begin
                    pci_write(bh, a, d, cbe, rdy, term, tail);
                    tries++;
                end
                checks++;
                if (!rdy) begin
                    errors++;
                    $display("FAIL rnd_wr%0d: not accepted after %0d attempts", n, tries);
                end else begin
                    exp_q.push_back('{addr: {3'(bar), a}, data: d, strb: ~cbe});
                end
            end else begin
                r_delay = $urandom_range(0, 6);
                tries = 0;
                res = 1;
                while (res == 1 && tries < 10) begin
                    pci_read(bh, a, res, d, cyc, tail);
                    tries++;
                end
                checks++;
                if (res != 0 || d !== mem_fn({3'(bar), a})) begin
                    errors++;
                    $display("FAIL rnd_rd%0d: result=%0d data=%h required 0 / %h", n, res, d, mem_fn({3'(bar), a}));
                end
            end
        end
        wait_drain("random");
        compare_writes("random", base);
        rand_mode = 0;
        r_delay = 3;
    endtask

    task automatic test_rst_mid();
        logic rdy, term;
        logic [2:0] tail;
        logic [45:0] obs;
        int base;
        aw_hold = 1;
        pci_write(8'h01, 24'h000030, 32'hCAFE_F00D, 4'h0, rdy, term, tail);
        step();
        checks++;
        if (level !== 3'd1 || awvalid !== 1'b1) begin
            errors++;
            $display("FAIL rst_setup: level=%0d awvalid=%b required 1/1", level, awvalid);
        end
        rst = 1;
        #1;
        obs = {s_ready, s_term, s_abort, awvalid, wvalid, bready, arvalid, rready, wr_err, level, adio_in};
        checks++;
        if (obs !== '0) begin
            errors++;
            $display("FAIL rst_mid_state: outputs=%h required 0", obs);
        end
        step();
        step();
        rst = 0;
        aw_hold = 0;
        base = axi_wr_q.size();
        repeat (6) step();
        checks++;
        if (level !== 3'd0 || awvalid !== 1'b0 || axi_wr_q.size() != base) begin
            errors++;
            $display("FAIL rst_abandon: level=%0d awvalid=%b new writes=%0d required 0/0/0",
                     level, awvalid, axi_wr_q.size() - base);
        end
        exp_q.delete();
        exp_q.push_back('{addr: {3'd7, 24'h00ABC0}, data: 32'h0BAD_CAFE, strb: 4'b1010});
        pci_write(8'h80, 24'h00ABC0, 32'h0BAD_CAFE, 4'b0101, rdy, term, tail);
        wait_drain("after_rst");
        compare_writes("after_rst", base);
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_fifo_full();
        test_read_basic();
        test_read_retry();
        test_read_err();
        test_bresp_err();
        test_random();
        test_rst_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end
endmodule
